ddr_arbiter: RTL



---
 rtl/ddr_arb_pkg.sv | 9 +
 rtl/ddr_ift.sv | 24 ++
 rtl/ddr_arb_pick.sv | 26 ++
 rtl/ddr_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types for the DDR port arbiter: FSM states, transaction op, owner indices.
// Policy macro DDR_ARB_RR_EN (round-robin when defined, dmem-first otherwise).
package ddr_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
  typedef enum logic {OP_READ, OP_WRITE} arb_op_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
endpackage

// File: rtl/ddr_ift.sv
// Cache memory-side DDR bundle; Master drives the request, Slave answers it.
interface DDR_ift #(
  parameter int ADDR_W = 64,
  parameter int LINE_W = 128
);
  logic                ren_mem;
  logic                wen_mem;
  logic [ADDR_W-1:0]   raddr_mem;
  logic [ADDR_W-1:0]   waddr_mem;
  logic [LINE_W-1:0]   wdata_mem;
  logic [LINE_W/8-1:0] wmask_mem;
  logic                rvalid_mem;
  logic                wvalid_mem;
  logic [LINE_W-1:0]   rdata_mem;

  modport Master (
    output ren_mem, wen_mem, raddr_mem, waddr_mem, wdata_mem, wmask_mem,
    input  rvalid_mem, wvalid_mem, rdata_mem
  );
  modport Slave (
    input  ren_mem, wen_mem, raddr_mem, waddr_mem, wdata_mem, wmask_mem,
    output rvalid_mem, wvalid_mem, rdata_mem
  );
endinterface

// File: rtl/ddr_arb_pick.sv
// Combinational requester select. DDR_ARB_RR_EN: ties go to rr_ptr; else dmem wins ties.
module ddr_arb_pick
  import ddr_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       idx,
  output logic       vld
);
  always_comb begin
    vld = |req;
    idx = OWN_I;
`ifdef DDR_ARB_RR_EN
    if (&req)            idx = rr_ptr;
    else if (req[OWN_D]) idx = OWN_D;
`else
    if (req[OWN_D])      idx = OWN_D;
`endif
  end

`ifndef DDR_ARB_RR_EN
  // Fixed priority ignores the pointer; keep the port for a uniform hookup.
  logic unused_rr;
  assign unused_rr = rr_ptr;
`endif
endmodule

// File: rtl/ddr_arbiter.sv
// Shares one DDR port between imem and dmem, one whole transaction at a time.
// Policy macro DDR_ARB_RR_EN (round-robin when defined, dmem-first otherwise).
module ddr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int LINE_W = 128
) (
  input  logic       clk,
  input  logic       rstn,
  DDR_ift.Slave      imem,
  DDR_ift.Slave      dmem,
  DDR_ift.Master     mem,
  output logic [1:0] grant_o
);
  arb_state_t state_q, state_d;
  arb_op_t    op_q, op_d;
  logic       owner_q, owner_d;
  logic       rr_ptr;
  logic [1:0] req;
  logic       pick_idx, pick_vld, pick_wen;

  logic                o_ren, o_wen;
  logic [ADDR_W-1:0]   o_raddr, o_waddr;
  logic [LINE_W-1:0]   o_wdata;
  logic [LINE_W/8-1:0] o_wmask;

`ifdef DDR_ARB_RR_EN
  logic rr_q, rr_d;
  assign rr_ptr = rr_q;
`else
  assign rr_ptr = OWN_I;
`endif

  assign req      = {dmem.ren_mem | dmem.wen_mem, imem.ren_mem | imem.wen_mem};
  assign pick_wen = (pick_idx == OWN_D) ? dmem.wen_mem : imem.wen_mem;

  ddr_arb_pick u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .idx    (pick_idx),
    .vld    (pick_vld)
  );

  always_comb begin
    if (owner_q == OWN_D) begin
      o_ren   = dmem.ren_mem;    o_wen   = dmem.wen_mem;
      o_raddr = dmem.raddr_mem;  o_waddr = dmem.waddr_mem;
      o_wdata = dmem.wdata_mem;  o_wmask = dmem.wmask_mem;
    end else begin
      o_ren   = imem.ren_mem;    o_wen   = imem.wen_mem;
      o_raddr = imem.raddr_mem;  o_waddr = imem.waddr_mem;
      o_wdata = imem.wdata_mem;  o_wmask = imem.wmask_mem;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_d    = op_q;
`ifdef DDR_ARB_RR_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: if (pick_vld) begin
        owner_d = pick_idx;
        // ren+wen together is treated as a write
        op_d    = pick_wen ? OP_WRITE : OP_READ;
        state_d = BUSY;
      end
      BUSY: if ((op_q == OP_READ  && mem.rvalid_mem) ||
                (op_q == OP_WRITE && mem.wvalid_mem)) state_d = DONE;
      DONE: begin
        state_d = IDLE;
`ifdef DDR_ARB_RR_EN
        rr_d    = ~owner_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      op_q    <= OP_READ;
`ifdef DDR_ARB_RR_EN
      rr_q    <= OWN_I;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
`ifdef DDR_ARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  always_comb begin
    mem.ren_mem     = 1'b0;
    mem.wen_mem     = 1'b0;
    mem.raddr_mem   = '0;
    mem.waddr_mem   = '0;
    mem.wdata_mem   = '0;
    mem.wmask_mem   = '0;
    imem.rvalid_mem = 1'b0;
    imem.wvalid_mem = 1'b0;
    imem.rdata_mem  = '0;
    dmem.rvalid_mem = 1'b0;
    dmem.wvalid_mem = 1'b0;
    dmem.rdata_mem  = '0;
    grant_o         = 2'b00;
    if (state_q == BUSY) begin
      mem.ren_mem   = (op_q == OP_READ)  & o_ren;
      mem.wen_mem   = (op_q == OP_WRITE) & o_wen;
      mem.raddr_mem = o_raddr;
      mem.waddr_mem = o_waddr;
      mem.wdata_mem = o_wdata;
      mem.wmask_mem = o_wmask;
      grant_o[owner_q] = 1'b1;
      // Responses are forwarded regardless of type; only FSM completion is op-checked
      if (owner_q == OWN_D) begin
        dmem.rvalid_mem = mem.rvalid_mem;
        dmem.wvalid_mem = mem.wvalid_mem;
        dmem.rdata_mem  = mem.rdata_mem;
      end else begin
        imem.rvalid_mem = mem.rvalid_mem;
        imem.wvalid_mem = mem.wvalid_mem;
        imem.rdata_mem  = mem.rdata_mem;
      end
    end
  end
endmodule
